// File: rtl/hwic_pin_checker.sv
// hwic_pin_checker
// Board bring-up receiver for the HWIC pin test. Synchronizes a bank of
// asynchronous pins, records which pins toggled during each fixed-length
// window and how many edges one selected pin produced, and hands the result
// to a consumer over valid/ready with a sticky overrun flag.

module hwic_pin_checker #(
  parameter int NPINS      = 32,
  parameter int WIN_CYCLES = 2**20,
  parameter int EDGE_W     = 16,
  parameter int SEL_W      = 5
) (
  input  logic              clk25,
  input  logic              rst_,
  input  logic              enable,
  input  logic [NPINS-1:0]  pins,
  input  logic [SEL_W-1:0]  sel_pin,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [NPINS-1:0]  res_mask,
  output logic [EDGE_W-1:0] res_edges,
  output logic              all_active,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int WCNT_W   = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int SEL_SPAN = 2**SEL_W;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN_CYCLES - 1);
  localparam logic [EDGE_W-1:0] ECNT_MAX  = '1;

  logic [NPINS-1:0]    sync1;
  logic [NPINS-1:0]    sync2;
  logic [NPINS-1:0]    sync3;
  logic [NPINS-1:0]    pin_edge;
  logic [NPINS-1:0]    seen;
  logic [NPINS-1:0]    snap_mask;
  logic [SEL_SPAN-1:0] edge_pad;
  logic [WCNT_W-1:0]   wcnt;
  logic [EDGE_W-1:0]   ecnt;
  logic [EDGE_W-1:0]   ecnt_sum;
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    sel_cur;
  logic                en_d;
  logic                win_start;
  logic                sel_hit;
  logic                tc;
  logic                accept;
  logic                ovr_set;

  // Two synchronizer stages plus a history stage so both pin edges are visible
  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign pin_edge = sync2 ^ sync3;

  // Window control, selected-pin edge lookup and the saturating count for this cycle
  always_comb begin
    win_start = enable & ~en_d;
    // The first window cycle has no captured select yet, so use the live one
    sel_cur   = win_start ? sel_pin : sel_q;
    edge_pad  = '0;
    edge_pad[NPINS-1:0] = pin_edge;
    // Indices past the last pin land on the zero padding and never count
    sel_hit   = edge_pad[sel_cur];
    tc        = enable && (wcnt == WCNT_LAST);
    snap_mask = seen | pin_edge;
    ecnt_sum  = ecnt;
    if (sel_hit && (ecnt != ECNT_MAX)) begin
      ecnt_sum = ecnt + EDGE_W'(1);
    end
    accept    = res_valid & res_ready;
    ovr_set   = tc & res_valid & ~res_ready;
  end

  // Window counter and per-window accumulators, cleared when disabled or at window end
  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      wcnt <= '0;
      seen <= '0;
      ecnt <= '0;
    end else if (!enable || tc) begin
      wcnt <= '0;
      seen <= '0;
      ecnt <= '0;
    end else begin
      wcnt <= wcnt + WCNT_W'(1);
      seen <= snap_mask;
      ecnt <= ecnt_sum;
    end
  end

  // Latch the pin select at the start of every window
  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      en_d  <= 1'b0;
      sel_q <= '0;
    end else begin
      en_d <= enable;
      if (win_start || tc) begin
        sel_q <= sel_pin;
      end
    end
  end

  // Result register: a snapshot at window end takes priority over an accept
  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      res_valid  <= 1'b0;
      res_mask   <= '0;
      res_edges  <= '0;
      all_active <= 1'b0;
    end else if (tc) begin
      res_valid  <= 1'b1;
      res_mask   <= snap_mask;
      res_edges  <= ecnt_sum;
      all_active <= &snap_mask;
    end else if (accept) begin
      res_valid  <= 1'b0;
      all_active <= 1'b0;
    end
  end

  // Sticky overrun; a new overrun beats a clear in the same cycle
  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hwic_pin_checker.sv
// tb_hwic_pin_checker
// Directed scenarios followed by a randomized run, all compared every cycle
// against a window-level reference model built from pin history.

module tb_hwic_pin_checker;

  localparam int NPINS = 8;
  localparam int WIN   = 16;
  localparam int SEL_W = 4;

  logic             clk25 = 1'b0;
  logic             rst_;
  logic             enable;
  logic [NPINS-1:0] pins;
  logic [SEL_W-1:0] sel_pin;
  logic             res_ready;
  logic             ovr_clr;

  logic             res_valid, all_active, overrun;
  logic [NPINS-1:0] res_mask;
  logic [15:0]      res_edges;
  logic             res_valid4, all_active4, overrun4;
  logic [NPINS-1:0] res_mask4;
  logic [3:0]       res_edges4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mode = 0;

  // Reference model state
  logic [NPINS-1:0] h0, h1, h2;
  int               m_pos;
  logic             m_prev_en;
  int               m_win_sel;
  logic [NPINS-1:0] m_acc;
  int               m_raw;
  logic             m_valid;
  logic [NPINS-1:0] m_mask;
  int               m_edges;
  logic             m_ovr;

  hwic_pin_checker #(
    .NPINS(NPINS), .WIN_CYCLES(WIN), .EDGE_W(16), .SEL_W(SEL_W)
  ) u_dut (
    .clk25(clk25), .rst_(rst_), .enable(enable), .pins(pins), .sel_pin(sel_pin),
    .res_valid(res_valid), .res_ready(res_ready), .res_mask(res_mask),
    .res_edges(res_edges), .all_active(all_active), .overrun(overrun),
    .ovr_clr(ovr_clr)
  );

  hwic_pin_checker #(
    .NPINS(NPINS), .WIN_CYCLES(WIN), .EDGE_W(4), .SEL_W(SEL_W)
  ) u_dut4 (
    .clk25(clk25), .rst_(rst_), .enable(enable), .pins(pins), .sel_pin(sel_pin),
    .res_valid(res_valid4), .res_ready(res_ready), .res_mask(res_mask4),
    .res_edges(res_edges4), .all_active(all_active4), .overrun(overrun4),
    .ovr_clr(ovr_clr)
  );

  // Free-running 25 MHz-style clock
  always #5 clk25 = ~clk25;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h0 = '0; h1 = '0; h2 = '0;
    m_pos = 0; m_prev_en = 1'b0; m_win_sel = 0; m_acc = '0; m_raw = 0;
    m_valid = 1'b0; m_mask = '0; m_edges = 0; m_ovr = 1'b0;
  endtask

  // One clock of the model: pins reach the edge detector three samples late
  task automatic model_step(input logic [NPINS-1:0] p, input logic en, input int sel,
                            input logic rdy, input logic clr);
    logic [NPINS-1:0] e;
    logic             snap;
    logic             set_ovr;
    e = h1 ^ h2;
    snap = 1'b0;
    set_ovr = 1'b0;
    if (!en) begin
      m_pos = 0; m_acc = '0; m_raw = 0;
    end else begin
      if (!m_prev_en) m_win_sel = sel;
      m_acc = m_acc | e;
      if (m_win_sel < NPINS && e[m_win_sel]) m_raw++;
      if (m_pos == WIN - 1) begin
        snap = 1'b1;
        set_ovr = m_valid && !rdy;
        m_mask = m_acc; m_edges = m_raw; m_valid = 1'b1;
        m_acc = '0; m_raw = 0; m_pos = 0; m_win_sel = sel;
      end else begin
        m_pos++;
      end
    end
    if (!snap && m_valid && rdy) m_valid = 1'b0;
    if (set_ovr) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_prev_en = en;
    h2 = h1; h1 = h0; h0 = p;
  endtask

  task automatic check_output();
    check("res_valid",   32'(res_valid),   32'(m_valid));
    check("overrun",     32'(overrun),     32'(m_ovr));
    check("res_mask",    32'(res_mask),    32'(m_mask));
    check("res_edges",   32'(res_edges),   32'(sat(m_edges, 65535)));
    check("all_active",  32'(all_active),  32'(m_valid & (&m_mask)));
    check("res_valid4",  32'(res_valid4),  32'(m_valid));
    check("overrun4",    32'(overrun4),    32'(m_ovr));
    check("res_mask4",   32'(res_mask4),   32'(m_mask));
    check("res_edges4",  32'(res_edges4),  32'(sat(m_edges, 15)));
    check("all_active4", 32'(all_active4), 32'(m_valid & (&m_mask4_exp())));
  endtask

  function automatic logic [NPINS-1:0] m_mask4_exp();
    return m_mask;
  endfunction

  // Drive this cycle's pins, clock once, advance the model and compare
  task automatic apply_stimulus();
    logic [NPINS-1:0] c_pins;
    logic             c_rst, c_en, c_rdy, c_clr;
    int               c_sel;
    case (mode)
      1: if (cyc % 2 == 0) pins[3] = ~pins[3];
      2: pins[0] = ~pins[0];
      3: pins = ~pins;
      4: pins = pins ^ (NPINS'($urandom) & NPINS'($urandom) & NPINS'($urandom));
      default: ;
    endcase
    c_pins = pins; c_rst = rst_; c_en = enable; c_rdy = res_ready;
    c_clr = ovr_clr; c_sel = int'(sel_pin);
    @(posedge clk25);
    #1;
    cyc++;
    if (!c_rst) model_reset();
    else model_step(c_pins, c_en, c_sel, c_rdy, c_clr);
    check_output();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      apply_stimulus();
      n++;
    end while (res_valid !== 1'b1 && n < budget);
    if (res_valid !== 1'b1) begin
      checks++;
      errors++;
      $error("[TB] FAIL wait_valid: observed=timeout expected=res_valid within %0d cycles", budget);
    end
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (m_pos != p && n < 4 * WIN) begin
      apply_stimulus();
      n++;
    end
  endtask

  initial begin
    int n;
    rst_ = 1'b1; enable = 1'b0; pins = 8'h5A; sel_pin = 4'd3;
    res_ready = 1'b1; ovr_clr = 1'b0;
    model_reset();
    #2 rst_ = 1'b0;
    #1 check_output();
    run(2);
    rst_ = 1'b1;

    $display("[TB] constant pins");
    enable = 1'b1;
    wait_valid(40, n);
    wait_valid(40, n);
    check("t1_mask",  32'(res_mask),   32'h00);
    check("t1_edges", 32'(res_edges),  32'd0);
    check("t1_all",   32'(all_active), 32'd0);

    $display("[TB] pin 3 toggling every 2 cycles");
    mode = 1;
    wait_valid(40, n);
    wait_valid(40, n);
    check("t2_mask",  32'(res_mask),  32'h08);
    check("t2_edges", 32'(res_edges), 32'd8);

    $display("[TB] pin 0 toggling every cycle, narrow counter saturates");
    mode = 2; sel_pin = 4'd0;
    wait_valid(40, n);
    wait_valid(40, n);
    check("t3_edges4", 32'(res_edges4), 32'd15);
    check("t3_edges",  32'(res_edges),  32'd16);
    check("t3_mask",   32'(res_mask),   32'h01);

    $display("[TB] overrun with consumer stalled");
    mode = 0;
    wait_valid(40, n);
    res_ready = 1'b0;
    run(WIN);
    run(4);
    for (int i = 0; i < 5; i++) begin
      pins[1] = ~pins[1];
      apply_stimulus();
    end
    run(7);
    check("t4_ovr",   32'(overrun),   32'd1);
    check("t4_mask",  32'(res_mask),  32'h02);
    check("t4_valid", 32'(res_valid), 32'd1);
    ovr_clr = 1'b1;
    apply_stimulus();
    ovr_clr = 1'b0;
    check("t4_clr_ovr",   32'(overrun),   32'd0);
    check("t4_clr_valid", 32'(res_valid), 32'd1);

    $display("[TB] accept on the terminal cycle");
    wait_pos(WIN - 1);
    res_ready = 1'b1;
    apply_stimulus();
    res_ready = 1'b0;
    check("t5_valid", 32'(res_valid), 32'd1);
    check("t5_ovr",   32'(overrun),   32'd0);
    check("t5_mask",  32'(res_mask),  32'h00);
    res_ready = 1'b1;

    $display("[TB] reset mid-window with all pins toggling");
    mode = 3;
    wait_pos(7);
    #2 rst_ = 1'b0;
    #1;
    check("t6_rst_valid", 32'(res_valid),  32'd0);
    check("t6_rst_mask",  32'(res_mask),   32'd0);
    check("t6_rst_edges", 32'(res_edges),  32'd0);
    check("t6_rst_all",   32'(all_active), 32'd0);
    check("t6_rst_ovr",   32'(overrun),    32'd0);
    model_reset();
    enable = 1'b0;
    run(2);
    rst_ = 1'b1;
    run(3);
    enable = 1'b1;
    wait_valid(40, n);
    check("t6_latency", 32'(n), 32'd16);
    wait_valid(40, n);
    check("t6_all", 32'(all_active), 32'd1);

    $display("[TB] randomized traffic");
    mode = 4;
    for (int i = 0; i < 1500; i++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      ovr_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 19) == 0) sel_pin = SEL_W'($urandom_range(0, 11));
      if (enable) enable = ($urandom_range(0, 99) != 0);
      else enable = ($urandom_range(0, 3) == 0);
      apply_stimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
